hazard_unit: RTL

Parametrised hazard and forwarding controller for the five-stage pipelined CPU, replacing the fixed two-source forwarding unit. It keeps its own scoreboard of in-flight destination registers, fed from the ID stage. From that scoreboard it generates registered forwarding selects for the EXE operands, a load-use stall, and branch flushes. It also exposes saturating stall/flush counters for performance measurement.

---
 rtl/hazard_unit_if.sv | 41 ++++
 rtl/hazard_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: ID-stage instruction description and branch resolution
// going in, stall/flush/forward controls and event counters coming out.
interface hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_dst;
  logic             id_we;
  logic             id_load;
  logic             branch_taken;

  logic             stall;
  logic             flush_if_id;
  logic             flush_id_exe;
  logic [SEL_W-1:0] fwd_a;
  logic [SEL_W-1:0] fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: describes the ID instruction, consumes the controls.
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_we,
           id_load, branch_taken,
    input  stall, flush_if_id, flush_id_exe, fwd_a, fwd_b, stall_cnt,
           flush_cnt
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_we,
           id_load, branch_taken,
    output stall, flush_if_id, flush_id_exe, fwd_a, fwd_b, stall_cnt,
           flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the five-stage pipeline. Tracks the
// destination registers of in-flight instructions, produces registered EXE
// operand forwarding selects, a load-use stall, branch flushes and
// saturating stall/flush event counters.
module hazard_unit #(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  hazard_unit_if.slave bus
);

  // The oldest (WB) slot is never matched because the register file reads
  // write-first, so only the forwardable slots EXE..DEPTH-2 are stored.
  localparam int TRACK = DEPTH - 1;

  logic             sb_vld  [TRACK];
  logic [REG_W-1:0] sb_dst  [TRACK];
  logic             sb_load [TRACK];

  logic [SEL_W-1:0] fwd_a_p1;
  logic [SEL_W-1:0] fwd_b_p1;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             ld_a;
  logic             ld_b;
  logic             raw_stall;
  logic             stall;
  logic             enter;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  // Newest-match search: scan oldest to newest so the youngest producer wins.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    for (int k = TRACK - 1; k >= 0; k--) begin
      if (bus.id_use_rs && (bus.id_rs != '0) && sb_vld[k] &&
          (sb_dst[k] == bus.id_rs)) begin
        sel_a = SEL_W'(k + 1);
        ld_a  = sb_load[k] && (k < LOAD_LAT);
      end
      if (bus.id_use_rt && (bus.id_rt != '0) && sb_vld[k] &&
          (sb_dst[k] == bus.id_rt)) begin
        sel_b = SEL_W'(k + 1);
        ld_b  = sb_load[k] && (k < LOAD_LAT);
      end
    end
  end

  // A taken branch squashes the ID instruction, so it overrides the stall.
  assign raw_stall = ld_a | ld_b;
  assign stall     = raw_stall & ~bus.branch_taken;
  assign enter     = bus.id_valid & ~stall & ~bus.branch_taken;

  // ---- ID -> EXE boundary: scoreboard valids, forward selects, counters ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < TRACK; k++) sb_vld[k] <= 1'b0;
      fwd_a_p1    <= '0;
      fwd_b_p1    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_vld[0] <= enter & bus.id_we & (bus.id_dst != '0);
      for (int k = 1; k < TRACK; k++) sb_vld[k] <= sb_vld[k-1];
      fwd_a_p1    <= enter ? sel_a : '0;
      fwd_b_p1    <= enter ? sel_b : '0;
      stall_cnt_q <= sat_inc(stall_cnt_q, stall);
      flush_cnt_q <= sat_inc(flush_cnt_q, bus.branch_taken);
    end
  end

  // Scoreboard payload shifts alongside the valids; it is qualified by them.
  always_ff @(posedge clock) begin
    sb_dst[0]  <= bus.id_dst;
    sb_load[0] <= bus.id_load;
    for (int k = 1; k < TRACK; k++) begin
      sb_dst[k]  <= sb_dst[k-1];
      sb_load[k] <= sb_load[k-1];
    end
  end

  assign bus.stall        = stall;
  assign bus.flush_if_id  = bus.branch_taken;
  assign bus.flush_id_exe = bus.branch_taken;
  assign bus.fwd_a        = fwd_a_p1;
  assign bus.fwd_b        = fwd_b_p1;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule
